// File: rtl/sram_arbiter_pkg.sv
// Shared encodings for the fetch/data SRAM-port arbiter: FSM states, owner IDs,
// access sizes and the round-robin owner selection.
package sram_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_e;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_e;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // On a collision the requester that did not win last time gets the port.
    function automatic owner_e pick_owner(input logic inst_req, input logic data_req,
                                          input owner_e last_grant);
        owner_e pick;
        if (inst_req && data_req) begin
            pick = (last_grant == OWN_INST) ? OWN_DATA : OWN_INST;
        end else if (data_req) begin
            pick = OWN_DATA;
        end else begin
            pick = OWN_INST;
        end
        return pick;
    endfunction

endpackage

// File: rtl/sram_arbiter.sv
// Shares one sram-like memory port between an instruction-fetch and a data
// requester, one transaction in flight at a time, round-robin on collisions.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,

    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_addr_ok,
    output logic              i_data_ok,
    output logic [DATA_W-1:0] i_rdata,

    input  logic              d_req,
    input  logic              d_wr,
    input  logic [1:0]        d_size,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_addr_ok,
    output logic              d_data_ok,
    output logic [DATA_W-1:0] d_rdata,

    output logic              m_req,
    output logic              m_wr,
    output logic [1:0]        m_size,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_addr_ok,
    input  logic              m_data_ok,
    input  logic [DATA_W-1:0] m_rdata
);

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    owner_e            last_grant_q, last_grant_d;
    logic              wr_q, wr_d;
    logic [1:0]        size_q, size_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic              m_req_s;
    logic              i_addr_ok_s, i_data_ok_s;
    logic              d_addr_ok_s, d_data_ok_s;

    // Next-state, request latching and handshake decode.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        wr_d         = wr_q;
        size_d       = size_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        m_req_s      = 1'b0;
        i_addr_ok_s  = 1'b0;
        i_data_ok_s  = 1'b0;
        d_addr_ok_s  = 1'b0;
        d_data_ok_s  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_req || d_req) begin
                    owner_d = pick_owner(i_req, d_req, last_grant_q);
                    if (owner_d == OWN_DATA) begin
                        wr_d    = d_wr;
                        size_d  = d_size;
                        addr_d  = d_addr;
                        wdata_d = d_wdata;
                    end else begin
                        // Fetches are always word reads.
                        wr_d    = 1'b0;
                        size_d  = SIZE_WORD;
                        addr_d  = i_addr;
                        wdata_d = {DATA_W{1'b0}};
                    end
                    state_d = ST_ADDR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ADDR: begin
                m_req_s = 1'b1;
                // A data_ok arriving with addr_ok here is stray and dropped.
                if (m_addr_ok) begin
                    if (owner_q == OWN_DATA) begin
                        d_addr_ok_s = 1'b1;
                    end else begin
                        i_addr_ok_s = 1'b1;
                    end
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_ADDR;
                end
            end
            ST_DATA: begin
                if (m_data_ok) begin
                    if (owner_q == OWN_DATA) begin
                        d_data_ok_s = 1'b1;
                    end else begin
                        i_data_ok_s = 1'b1;
                    end
                    last_grant_d = owner_q;
                    state_d      = ST_IDLE;
                end else begin
                    state_d = ST_DATA;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, owner, arbitration history and latched request fields.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_INST;
            last_grant_q <= OWN_INST;
            wr_q         <= 1'b0;
            size_q       <= 2'd0;
            addr_q       <= {ADDR_W{1'b0}};
            wdata_q      <= {DATA_W{1'b0}};
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            wr_q         <= wr_d;
            size_q       <= size_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
        end
    end

    assign m_req     = m_req_s;
    assign m_wr      = wr_q;
    assign m_size    = size_q;
    assign m_addr    = addr_q;
    assign m_wdata   = wdata_q;

    assign i_addr_ok = i_addr_ok_s;
    assign i_data_ok = i_data_ok_s;
    assign d_addr_ok = d_addr_ok_s;
    assign d_data_ok = d_data_ok_s;

    assign i_rdata   = m_rdata;
    assign d_rdata   = m_rdata;

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, giving address width for all address ports.
REQ-002 The block SHALL have parameter DATA_W, default 32, giving data width for all data ports.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low: clk  in  1  rising-edge clock.
REQ-004 resetn  in  1  asynchronous active-low reset.
REQ-005 i_req  in  1  instruction-fetch request; i_addr  in  ADDR_W  fetch address.
REQ-006 i_addr_ok  out  1  fetch address accepted; i_data_ok  out  1  fetch data valid; i_rdata  out  DATA_W  fetch data.
REQ-007 d_req  in  1  data request; d_wr  in  1  1=store; d_size  in  2  0=byte,1=half,2=word; d_addr  in  ADDR_W; d_wdata  in  DATA_W.
REQ-008 d_addr_ok  out  1; d_data_ok  out  1; d_rdata  out  DATA_W  (data-side equivalents of REQ-006).
REQ-009 m_req  out  1; m_wr  out  1; m_size  out  2; m_addr  out  ADDR_W; m_wdata  out  DATA_W  shared memory port request.
REQ-010 m_addr_ok  in  1; m_data_ok  in  1; m_rdata  in  DATA_W  shared memory port response.

Function
REQ-011 The block SHALL share one sram-like memory port between fetch and data requesters with at most one transaction outstanding.
REQ-012 FSM states SHALL be IDLE, ADDR, DATA; fetch requests SHALL be presented to memory with m_wr=0, m_size=2.
REQ-013 IDLE: with any request pending, the block SHALL select an owner, latch its wr/size/addr/wdata into registers and go to ADDR next cycle; no request -> stay IDLE.
REQ-014 Arbitration: only one requester -> grant it; both -> grant the one not granted last (round-robin); last_grant after reset = fetch, so data wins first collision.
REQ-015 ADDR: m_req=1 with latched fields; on m_addr_ok=1 the block SHALL assert the owner's addr_ok in the same cycle (combinational) and go to DATA.
REQ-016 DATA: m_req=0; on m_data_ok=1 the block SHALL assert the owner's data_ok in the same cycle, update last_grant, and go to IDLE.
REQ-017 m_rdata SHALL drive both i_rdata and d_rdata directly; values are qualified only by the matching data_ok.
REQ-018 Latency: request sampled in IDLE at cycle N -> m_req at N+1; minimum one IDLE cycle between consecutive transactions.
REQ-019 m_data_ok in IDLE or ADDR SHALL be ignored; m_addr_ok outside ADDR SHALL be ignored.
REQ-020 Simultaneous m_addr_ok and m_data_ok in ADDR: only m_addr_ok SHALL be acted on.
REQ-021 Stores SHALL still produce d_data_ok on m_data_ok; d_rdata is don't-care for stores.
REQ-022 A requester dropping req after grant SHALL NOT abort the transaction; it completes from latched fields.
REQ-023 Non-owner addr_ok/data_ok SHALL stay 0 at all times.

Reset
REQ-024 resetn=0 SHALL asynchronously force state IDLE, last_grant=fetch, latched fields 0, all outputs 0 except rdata pass-throughs.
REQ-025 Reset mid-transaction SHALL abandon it with no addr_ok/data_ok issued; after release the first request starts a new transaction from IDLE.

Structure
REQ-026 A shared package SHALL hold the FSM state encoding, owner encoding (OWN_INST=0, OWN_DATA=1) and size constants.
REQ-027 The block SHALL be a single module; no sub-module is needed.

Verification
REQ-028 Fetch only: i_req=1, i_addr=0xBFC00000, m_addr_ok at 2nd cycle, m_data_ok 2 cycles later with 0x3C080001 -> m_addr=0xBFC00000, i_addr_ok once, i_data_ok once with i_rdata=0x3C080001.
REQ-029 Collision after reset: i_req and d_req both 1 -> data store (d_addr=0x80001000, d_wdata=0xDEADBEEF, d_size=2) served first, fetch next; grants alternate over 4 back-to-back collisions.
REQ-030 Byte store: d_wr=1, d_size=0, d_addr=0x80000003 -> m_wr=1, m_size=0, m_addr=0x80000003, d_data_ok once.
REQ-031 Stray responses: m_data_ok pulsed in IDLE and with m_addr_ok in ADDR -> no data_ok until a later m_data_ok in DATA.
REQ-032 Reset in DATA: resetn low one cycle -> m_req=0, no data_ok; next fetch completes normally.
REQ-033 Memory stall: m_addr_ok held 0 for 10 cycles -> m_req and m_addr stable throughout, i_addr_ok 0 until acceptance.
